// File: rtl/vedic_mul_issue.sv
// Operand-issue and result-collection stage for the pipelined 64x64 Vedic multiplier.
// Registers accepted operand pairs onto the multiplier inputs. A token shift register
// follows each issued operation through the fixed multiplier latency. Products land in a
// first-word-fall-through FIFO. A credit counter covers tokens in flight plus stored
// entries, so a product can never arrive at a full FIFO.
module vedic_mul_issue #(
    parameter int unsigned LATENCY = 4,  // 1..16
    parameter int unsigned DEPTH   = 8   // power of two, >= LATENCY + 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_a,
    input  logic [63:0]  in_b,
    output logic [63:0]  mul_a,
    output logic [63:0]  mul_b,
    input  logic [127:0] mul_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_result,
    output logic [15:0]  tx_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [LATENCY-1:0] tok_q;
    logic [PW-1:0]      head_q;
    logic [PW-1:0]      tail_q;
    logic [CW-1:0]      occ_q;
    // Credits in use: tokens in flight plus FIFO occupancy.
    logic [CW-1:0]      used_q;
    logic [15:0]        count_q;
    logic [63:0]        a_q;
    logic [63:0]        b_q;
    logic [127:0]       mem [DEPTH];

    logic accept;
    logic write;
    logic pop;

    // Handshake decode and FIFO head presentation (masked to zero while empty).
    always_comb begin
        in_ready   = used_q < CW'(DEPTH);
        out_valid  = occ_q != '0;
        accept     = in_valid && in_ready;
        write      = tok_q[LATENCY-1];
        pop        = out_valid && out_ready;
        out_result = out_valid ? mem[head_q] : '0;
    end

    assign mul_a    = a_q;
    assign mul_b    = b_q;
    assign tx_count = count_q;

    // Operand registers load only on accept; non-issued cycles leave them untouched.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    // Token pipeline: a token entering at accept edge k drives the tap at edge k+LATENCY.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tok_q <= '0;
        end else begin
            tok_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                tok_q[i] <= tok_q[i-1];
            end
        end
    end

    // Pointers, occupancy, credits and pop counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            used_q  <= '0;
            count_q <= '0;
        end else begin
            if (write) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q  <= head_q + PW'(1);
                count_q <= count_q + 16'd1;
            end
            occ_q  <= occ_q + CW'(write) - CW'(pop);
            used_q <= used_q + CW'(accept) - CW'(pop);
        end
    end

    // FIFO storage; contents are don't-care after reset because occupancy gates the output.
    always_ff @(posedge CLK) begin
        if (write) begin
            mem[tail_q] <= mul_result;
        end
    end

endmodule

// File: tb/tb_vedic_mul_issue.sv
// Self-checking bench for vedic_mul_issue with a behavioural multiplier model.
// Accepted pairs push their hand-computed product into a queue; a monitor pops and
// compares whenever the DUT hands a product downstream.
module tb_vedic_mul_issue;

    localparam int unsigned LATENCY = 4;
    localparam int unsigned DEPTH   = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_a = '0;
    logic [63:0]  in_b = '0;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic [127:0] mul_result;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_result;
    logic [15:0]  tx_count;

    logic [127:0] exp_cur = '0;
    logic [127:0] exp_q[$];
    int           n_vec = 0;
    int           n_fail = 0;
    int           n_pops = 0;
    int           pops_since_rst = 0;
    logic         hold_prev = 1'b0;
    logic [127:0] res_prev = '0;

    // Multiplier model: operand register counts as the first stage, three more follow.
    logic [127:0] p1, p2, p3;
    always @(posedge CLK) begin
        p1 <= {64'd0, mul_a} * {64'd0, mul_b};
        p2 <= p1;
        p3 <= p2;
    end
    assign mul_result = p3;

    vedic_mul_issue #(
        .LATENCY(LATENCY),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_result(mul_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .tx_count  (tx_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle while inputs are stable.
    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
            pops_since_rst = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", {127'd0, out_valid}, 128'd1);
                chk("hold_result", out_result, res_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", out_result, 128'd0);
                    if (out_result == 128'd0) begin
                        n_fail++;
                        $display("FAIL unexpected_result: got a product with nothing outstanding");
                    end
                end else begin
                    chk("result", out_result, exp_q.pop_front());
                end
                n_pops++;
                pops_since_rst++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(exp_cur);
                chk("credit_bound", {127'd0, exp_q.size() > DEPTH}, 128'd0);
            end
            hold_prev = out_valid && !out_ready;
            res_prev  = out_result;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [63:0]  s4_a [8];
    logic [63:0]  s4_b [8];
    logic [127:0] s4_p [8];
    logic [127:0] s3_p [8];

    initial begin
        int n;
        int pops0;
        s3_p = '{128'd2, 128'd6, 128'd12, 128'd20, 128'd30, 128'd42, 128'd56, 128'd72};
        s4_a = '{64'd3, 64'd10, 64'd0, 64'd1, 64'd1000, 64'h1_0000_0000, 64'd12345, 64'd65535};
        s4_b = '{64'd5, 64'd10, 64'd99, 64'd1, 64'd1000, 64'h1_0000_0000, 64'd0, 64'd65537};
        s4_p = '{128'd15, 128'd100, 128'd0, 128'd1, 128'd1000000,
                 128'h1_0000_0000_0000_0000, 128'd0, 128'd4294967295};

        // 1: reset asserted mid-clock takes effect immediately
        #3 RST = 1'b1;
        #1;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_mul_a", {64'd0, mul_a}, 128'd0);
        chk("rst_mul_b", {64'd0, mul_b}, 128'd0);
        chk("rst_tx_count", {112'd0, tx_count}, 128'd0);
        chk("rst_out_result", out_result, 128'd0);
        tick();
        tick();
        RST = 1'b0;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);

        // 2: single operation, accept at edge 0
        in_valid = 1'b1;
        in_a = 64'd123456789;
        in_b = 64'd125;
        exp_cur = 128'd15432098625;
        tick();
        in_valid = 1'b0;
        chk("single_mul_a", {64'd0, mul_a}, 128'd123456789);
        tick();
        tick();
        tick();
        chk("single_not_yet", {127'd0, out_valid}, 128'd0);
        tick();
        chk("single_valid", {127'd0, out_valid}, 128'd1);
        chk("single_result", out_result, 128'd15432098625);
        out_ready = 1'b1;
        tick();
        chk("single_tx", {112'd0, tx_count}, 128'd1);
        chk("single_empty", {127'd0, out_valid}, 128'd0);

        // 3: streaming, one result per cycle
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_a = 64'(i + 1);
            in_b = 64'(i + 2);
            exp_cur = s3_p[i];
            chk("stream_in_ready", {127'd0, in_ready}, 128'd1);
            tick();
            chk("stream_valid", {127'd0, out_valid}, {127'd0, i >= 4});
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_tail_valid", {127'd0, out_valid}, 128'd1);
        end
        tick();
        chk("stream_done", {127'd0, out_valid}, 128'd0);
        chk("stream_tx", {112'd0, tx_count}, 128'd9);

        // 4: back-pressure fills all credits
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1;
            if (n < 8) begin
                in_a = s4_a[n];
                in_b = s4_b[n];
                exp_cur = s4_p[n];
            end
            if (in_ready) n++;
            tick();
        end
        chk("bp_accepts", 128'(n), 128'd8);
        chk("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        pops0 = n_pops;
        tick();
        chk("bp_credit_release", {127'd0, in_ready}, 128'd1);
        for (int i = 0; i < 7; i++) tick();
        chk("bp_drained", {127'd0, out_valid}, 128'd0);
        chk("bp_pop_count", 128'(n_pops - pops0), 128'd8);

        // 5: maximum operands
        in_valid = 1'b1;
        in_a = 64'hFFFF_FFFF_FFFF_FFFF;
        in_b = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_cur = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("max_tx", {112'd0, tx_count}, 128'd18);

        // 6: reset with tokens in flight and one product stored
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 64'(2 * i + 2);
            in_b = 64'(2 * i + 3);
            exp_cur = 128'((2 * i + 2) * (2 * i + 3));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_stored", {127'd0, out_valid}, 128'd1);
        #2 RST = 1'b1;
        #1;
        chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
        chk("mid_rst_tx", {112'd0, tx_count}, 128'd0);
        tick();
        RST = 1'b0;
        chk("mid_in_ready", {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1;
        in_a = 64'd7;
        in_b = 64'd6;
        exp_cur = 128'd42;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_tx", {112'd0, tx_count}, 128'd1);
        chk("mid_one_result", 128'(pops_since_rst), 128'd1);
        chk("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
